// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing the data memory between fetch and MEM-stage ports
module mem_port_arbiter #(
    parameter int XLEN        = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            p0_valid,
    input  logic [XLEN-1:0] p0_addr,
    output logic            p0_ready,
    output logic            p0_resp_valid,
    input  logic            p1_valid,
    input  logic            p1_write,
    input  logic [XLEN-1:0] p1_addr,
    input  logic [XLEN-1:0] p1_wdata,
    input  logic [2:0]      p1_size,
    output logic            p1_ready,
    output logic            p1_resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    output logic            mem_re,
    output logic [2:0]      mem_size,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [3:0] CNT_INIT  = 4'(MEM_LATENCY - 1);
    localparam logic [2:0] WORD_SIZE = 3'b010;

    logic [1:0]      state;
    logic            last_grant;
    logic            owner;
    logic            lat_write;
    logic [XLEN-1:0] lat_addr;
    logic [XLEN-1:0] lat_wdata;
    logic [2:0]      lat_size;
    logic [3:0]      cnt;
    logic [XLEN-1:0] rdata_q;
    logic            gnt0;
    logic            gnt1;

    // On a tie the port that did not win last time is served, giving strict alternation.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == S_IDLE) begin
            if (p0_valid && p1_valid) begin
                gnt0 = last_grant;
                gnt1 = !last_grant;
            end else begin
                gnt0 = p0_valid;
                gnt1 = p1_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_size   <= '0;
            cnt        <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt0 || gnt1) begin
                        owner      <= gnt1;
                        last_grant <= gnt1;
                        lat_write  <= gnt1 && p1_write;
                        lat_addr   <= gnt1 ? p1_addr : p0_addr;
                        lat_wdata  <= gnt1 ? p1_wdata : '0;
                        lat_size   <= gnt1 ? p1_size : WORD_SIZE;
                        cnt        <= CNT_INIT;
                        state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!lat_write) begin
                            rdata_q <= mem_rdata;
                        end
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign p0_ready      = gnt0;
    assign p1_ready      = gnt1;
    assign p0_resp_valid = (state == S_RESP) && !owner;
    assign p1_resp_valid = (state == S_RESP) && owner;
    assign resp_rdata    = rdata_q;
    assign busy          = (state != S_IDLE);

    // A store writes only while the counter still holds its load value, i.e. the first access cycle.
    assign mem_we    = (state == S_ACCESS) && lat_write && (cnt == CNT_INIT);
    assign mem_re    = (state == S_ACCESS) && !lat_write;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign mem_size  = lat_size;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed checks of mem_port_arbiter at latencies 1, 3, 4 and 15
module tb_mem_port_arbiter;
    localparam int XLEN = 32;
    localparam int NI   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            p0_valid;
    logic [XLEN-1:0] p0_addr;
    logic            p1_valid;
    logic            p1_write;
    logic [XLEN-1:0] p1_addr;
    logic [XLEN-1:0] p1_wdata;
    logic [2:0]      p1_size;

    logic            p0_ready_w   [NI];
    logic            p0_resp_w    [NI];
    logic            p1_ready_w   [NI];
    logic            p1_resp_w    [NI];
    logic [XLEN-1:0] rdata_w      [NI];
    logic [XLEN-1:0] mem_addr_w   [NI];
    logic [XLEN-1:0] mem_wdata_w  [NI];
    logic            mem_we_w     [NI];
    logic            mem_re_w     [NI];
    logic [2:0]      mem_size_w   [NI];
    logic [XLEN-1:0] mem_rdata_w  [NI];
    logic            busy_w       [NI];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 15;
        mem_port_arbiter #(.XLEN(XLEN), .MEM_LATENCY(LAT)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .p0_valid     (p0_valid),
            .p0_addr      (p0_addr),
            .p0_ready     (p0_ready_w[g]),
            .p0_resp_valid(p0_resp_w[g]),
            .p1_valid     (p1_valid),
            .p1_write     (p1_write),
            .p1_addr      (p1_addr),
            .p1_wdata     (p1_wdata),
            .p1_size      (p1_size),
            .p1_ready     (p1_ready_w[g]),
            .p1_resp_valid(p1_resp_w[g]),
            .resp_rdata   (rdata_w[g]),
            .mem_addr     (mem_addr_w[g]),
            .mem_wdata    (mem_wdata_w[g]),
            .mem_we       (mem_we_w[g]),
            .mem_re       (mem_re_w[g]),
            .mem_size     (mem_size_w[g]),
            .mem_rdata    (mem_rdata_w[g]),
            .busy         (busy_w[g])
        );
        assign mem_rdata_w[g] = model_rdata(mem_addr_w[g]);
    end

    typedef struct {
        logic        p0v;
        logic [31:0] p0a;
        logic        p1v;
        logic        p1w;
        logic [31:0] p1a;
        logic [31:0] p1d;
        logic [2:0]  p1s;
        logic [6:0]  fl;    // p0_ready,p1_ready,p0_resp,p1_resp,mem_re,mem_we,busy
        logic [2:0]  sz;
        logic [31:0] ma;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic p0v, input logic [31:0] p0a, input logic p1v,
                                input logic p1w, input logic [31:0] p1a, input logic [31:0] p1d,
                                input logic [2:0] p1s, input logic [6:0] fl, input logic [2:0] sz,
                                input logic [31:0] ma, input logic [31:0] rd);
        vec_t v;
        v.p0v = p0v; v.p0a = p0a; v.p1v = p1v; v.p1w = p1w; v.p1a = p1a; v.p1d = p1d;
        v.p1s = p1s; v.fl = fl; v.sz = sz; v.ma = ma; v.rd = rd;
        return v;
    endfunction

    function automatic logic [79:0] obs(input int k);
        return {6'd0, p0_ready_w[k], p1_ready_w[k], p0_resp_w[k], p1_resp_w[k], mem_re_w[k],
                mem_we_w[k], busy_w[k], mem_size_w[k], mem_addr_w[k], rdata_w[k]};
    endfunction

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic idle_inputs();
        p0_valid = 0; p0_addr = '0; p1_valid = 0; p1_write = 0;
        p1_addr = '0; p1_wdata = '0; p1_size = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    initial begin
        int we_cnt, resp_at, ng, nr, bad_rd, both;
        logic [2:0]  we_size;
        logic [31:0] we_addr, we_data, resp_rd;
        logic [5:0]  gbits, rbits;
        int          sw_idx [3];
        int          sw_lat [3];
        int          sw_resp [3];
        int          sw_busy [3];

        rst = 0;
        idle_inputs();
        tbl[0]  = mk(1, 32'h40,  0, 0, 0,       0,            0, 7'b1000000, 0, 32'h0,   32'h0);
        tbl[1]  = mk(0, 0,       0, 0, 0,       0,            0, 7'b0000101, 2, 32'h40,  32'h0);
        tbl[2]  = mk(0, 0,       0, 0, 0,       0,            0, 7'b0010001, 2, 32'h40,  32'hDEADBEEF);
        tbl[3]  = mk(0, 0,       1, 1, 32'h80,  32'h12345678, 0, 7'b0100000, 2, 32'h40,  32'hDEADBEEF);
        tbl[4]  = mk(0, 0,       0, 0, 0,       0,            0, 7'b0000011, 0, 32'h80,  32'hDEADBEEF);
        tbl[5]  = mk(0, 0,       0, 0, 0,       0,            0, 7'b0001001, 0, 32'h80,  32'hDEADBEEF);
        tbl[6]  = mk(0, 0,       1, 0, 32'h200, 0,            2, 7'b0100000, 0, 32'h80,  32'hDEADBEEF);
        tbl[7]  = mk(0, 0,       0, 0, 0,       0,            0, 7'b0000101, 2, 32'h200, 32'hDEADBEEF);
        tbl[8]  = mk(0, 0,       0, 0, 0,       0,            0, 7'b0001001, 2, 32'h200, 32'h5A5A0200);
        tbl[9]  = mk(1, 32'h300, 1, 0, 32'h10,  0,            2, 7'b1000000, 2, 32'h200, 32'h5A5A0200);
        tbl[10] = mk(0, 0,       1, 0, 32'h20,  0,            2, 7'b0000101, 2, 32'h300, 32'h5A5A0200);
        tbl[11] = mk(0, 0,       1, 0, 32'h20,  0,            2, 7'b0010001, 2, 32'h300, 32'h5A5A0300);
        tbl[12] = mk(0, 0,       1, 0, 32'h20,  0,            2, 7'b0100000, 2, 32'h300, 32'h5A5A0300);
        tbl[13] = mk(0, 0,       0, 0, 0,       0,            0, 7'b0000101, 2, 32'h20,  32'h5A5A0300);
        tbl[14] = mk(0, 0,       0, 0, 0,       0,            0, 7'b0001001, 2, 32'h20,  32'h5A5A0020);
        tbl[15] = mk(0, 0,       0, 0, 0,       0,            0, 7'b0000000, 2, 32'h20,  32'h5A5A0020);

        // Table vectors on the MEM_LATENCY=1 instance.
        apply_reset();
        #1 check("reset_state", obs(0), 80'h0);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            p0_valid = tbl[i].p0v; p0_addr = tbl[i].p0a;
            p1_valid = tbl[i].p1v; p1_write = tbl[i].p1w; p1_addr = tbl[i].p1a;
            p1_wdata = tbl[i].p1d; p1_size = tbl[i].p1s;
            #1 check($sformatf("vec%0d", i), obs(0),
                     {6'd0, tbl[i].fl, tbl[i].sz, tbl[i].ma, tbl[i].rd});
        end

        // Asynchronous reset in the second ACCESS cycle of a MEM_LATENCY=3 fetch.
        apply_reset();
        p0_valid = 1; p0_addr = 32'h500;
        @(negedge clk); p0_valid = 0;
        @(negedge clk);
        #1 check("busy_before_reset", {79'd0, busy_w[1]}, 80'd1);
        #1 rst = 0;
        #1 check("reset_async_clear", obs(1), 80'h0);
        @(negedge clk); rst = 1;
        nr = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (p0_resp_w[1] || p1_resp_w[1] || busy_w[1]) nr++;
        end
        check("no_resp_after_reset", 80'(nr), 80'd0);
        p0_valid = 1; p0_addr = 32'h100;
        #1 check("post_reset_grant", {79'd0, p0_ready_w[1]}, 80'd1);
        @(negedge clk); p0_valid = 0;
        #1 check("post_reset_addr", {47'd0, mem_re_w[1], mem_addr_w[1]}, {47'd0, 1'b1, 32'h100});
        repeat (5) @(negedge clk);

        // Store on the MEM_LATENCY=3 instance after a load that sets resp_rdata.
        apply_reset();
        p0_valid = 1; p0_addr = 32'h40;
        @(negedge clk); p0_valid = 0;
        repeat (5) @(negedge clk);
        p1_valid = 1; p1_write = 1; p1_addr = 32'h80; p1_wdata = 32'h12345678; p1_size = 3'b000;
        #1 check("store_ready", {79'd0, p1_ready_w[1]}, 80'd1);
        we_cnt = 0; resp_at = -1; we_size = 3'b111; we_addr = '0; we_data = '0; resp_rd = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            if (mem_we_w[1]) begin
                we_cnt++; we_size = mem_size_w[1]; we_addr = mem_addr_w[1]; we_data = mem_wdata_w[1];
            end
            if (p1_resp_w[1] && resp_at < 0) begin
                resp_at = k; resp_rd = rdata_w[1];
            end
        end
        check("store_we_count", 80'(we_cnt), 80'd1);
        check("store_we_payload", {13'd0, we_size, we_addr, we_data}, {13'd0, 3'b000, 32'h80, 32'h12345678});
        check("store_resp_cycle", 80'(resp_at), 80'd4);
        check("store_rdata_held", {48'd0, resp_rd}, {48'd0, 32'hDEADBEEF});

        // Continuous contention from reset on the MEM_LATENCY=3 instance.
        apply_reset();
        p0_valid = 1; p0_addr = 32'h1000;
        p1_valid = 1; p1_write = 0; p1_addr = 32'h2000; p1_size = 3'b010;
        ng = 0; nr = 0; bad_rd = 0; both = 0; gbits = '0; rbits = '0;
        for (int k = 0; k < 100 && nr < 6; k++) begin
            #1;
            if ((p0_ready_w[1] && p1_ready_w[1]) || (p0_resp_w[1] && p1_resp_w[1])) both++;
            if (ng < 6 && (p0_ready_w[1] || p1_ready_w[1])) begin
                gbits[ng] = p1_ready_w[1]; ng++;
            end
            if (p0_resp_w[1] || p1_resp_w[1]) begin
                rbits[nr] = p1_resp_w[1];
                if (rdata_w[1] !== model_rdata(p1_resp_w[1] ? 32'h2000 : 32'h1000)) bad_rd++;
                nr++;
            end
            @(negedge clk);
        end
        idle_inputs();
        check("contend_grant_order", {74'd0, gbits}, {74'd0, 6'b101010});
        check("contend_resp_order", {74'd0, rbits}, {74'd0, 6'b101010});
        check("contend_rdata", 80'(bad_rd), 80'd0);
        check("contend_exclusive", 80'(both), 80'd0);

        // Latency sweep: a single fetch issued to every instance at once.
        apply_reset();
        sw_idx = '{0, 2, 3};
        sw_lat = '{1, 4, 15};
        sw_resp = '{-1, -1, -1};
        sw_busy = '{0, 0, 0};
        p0_valid = 1; p0_addr = 32'h600;
        #1;
        for (int j = 0; j < 3; j++)
            check($sformatf("sweep_ready_L%0d", sw_lat[j]), {79'd0, p0_ready_w[sw_idx[j]]}, 80'd1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            p0_valid = 0;
            #1;
            for (int j = 0; j < 3; j++) begin
                if (busy_w[sw_idx[j]]) sw_busy[j]++;
                if (p0_resp_w[sw_idx[j]] && sw_resp[j] < 0) sw_resp[j] = k;
            end
        end
        for (int j = 0; j < 3; j++) begin
            check($sformatf("sweep_resp_L%0d", sw_lat[j]), 80'(sw_resp[j]), 80'(sw_lat[j] + 1));
            check($sformatf("sweep_busy_L%0d", sw_lat[j]), 80'(sw_busy[j]), 80'(sw_lat[j] + 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported data memory between two requesters: port 0 is the instruction fetch (read-only) and port 1 is the MEM-stage data access (read/write).
- Arbitrates round-robin, latches the winning request, and drives the memory for a parameterised fixed latency.
- Returns a one-cycle response pulse to the winner.
- Sits between the fetch/MEM stages and data_memory; the memory's UART side-band is untouched.

Parameters:
- XLEN, 32, data/address width.
- MEM_LATENCY, 1, cycles from memory access start to valid read data (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- p0_valid  in  1  fetch request valid.
- p0_addr  in  XLEN  fetch address.
- p0_ready  out  1  fetch request accepted this cycle.
- p0_resp_valid  out  1  fetch response pulse.
- p1_valid  in  1  data request valid.
- p1_write  in  1  1 = store, 0 = load.
- p1_addr  in  XLEN  data address.
- p1_wdata  in  XLEN  store data.
- p1_size  in  3  funct3 word size.
- p1_ready  out  1  data request accepted this cycle.
- p1_resp_valid  out  1  data response pulse (loads and stores).
- resp_rdata  out  XLEN  read data; valid with either resp pulse.
- mem_addr  out  XLEN  memory address.
- mem_wdata  out  XLEN  memory write data.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_size  out  3  memory word_size.
- mem_rdata  in  XLEN  memory read data.
- busy  out  1  arbiter not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, last_grant=1 (so port 0 wins the first tie).
  - All outputs 0: ready, resp_valid, mem_we, mem_re, busy, resp_rdata, and the latched addr/wdata/size.
  - A reset mid-access abandons the access; no response is ever issued for it.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Only one request valid: grant it.
  - Both valid: grant the port not equal to last_grant.
  - In the grant cycle, pX_ready=1 (combinational from valid and state, single cycle). Latch addr, wdata and size, plus write = p1_write or 0 for port 0. Update last_grant. Load cnt=MEM_LATENCY-1. Go to ACCESS.
  - No valid request: stay in IDLE.
- ACCESS:
  - mem_addr, mem_size and mem_wdata are driven from the latched registers.
  - mem_re=1 for every ACCESS cycle of a load.
  - mem_we=1 only in the first ACCESS cycle of a store (no duplicate writes).
  - cnt decrements each cycle. When cnt==0, capture mem_rdata into resp_rdata on loads (resp_rdata holds its value on stores) and go to RESP.
  - ACCESS therefore lasts exactly MEM_LATENCY cycles.
- RESP:
  - The granted port's resp_valid=1 for exactly one cycle, then return to IDLE.
  - No grant is issued in RESP, so the minimum request spacing per access is MEM_LATENCY+2 cycles.
- resp_rdata holds its value until the next load completes.
- busy=1 in ACCESS and RESP.
- Port 0 is always a read; mem_size for port 0 is 3'b010 (word).
- Requesters hold valid and payload stable until ready. Changes to payload while not ready are ignored; only the grant-cycle value is latched.
- Deasserting valid before grant withdraws the request with no side effects.
- Never both readies in one cycle; never both resp_valid in one cycle.
- Starvation bound: with both ports continuously requesting, grants alternate strictly 0,1,0,1...

Test Plan:
- Reset: rst low mid-ACCESS (MEM_LATENCY=3, cycle 2) -> all outputs 0 immediately, no resp_valid afterwards; after release, p0 request at 0x100 granted next cycle.
- Single fetch: p0_valid, addr=0x40, memory returns 0xDEADBEEF, MEM_LATENCY=1 -> p0_ready cycle 0, mem_re cycle 1, p0_resp_valid cycle 2 with resp_rdata=0xDEADBEEF.
- Store: p1 write addr=0x80, wdata=0x12345678, size=3'b000, MEM_LATENCY=3 -> mem_we high exactly one cycle with mem_size=0; p1_resp_valid 4 cycles after grant; resp_rdata unchanged.
- Contention: both valid continuously for 6 grants from reset -> grant order 0,1,0,1,0,1, and each response reaches the correct port.
- Payload change while waiting: p1 addr changes 0x10 to 0x20 while p0 owns the memory -> p1's access uses 0x20, the value at its grant.
- Latency sweep: MEM_LATENCY=1,4,15 -> resp_valid exactly MEM_LATENCY+1 cycles after the ready cycle; busy high for exactly MEM_LATENCY+1 cycles.
